// File: rtl/beta_exe_lsu.sv
// Execute-stage load/store unit: accepts one memory operation per enable and runs a
// single req/gnt/rvalid transaction on the data bus, returning aligned/extended load data.
module beta_exe_lsu #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lsu_en_i,
  input  logic                 lsu_op_i,
  input  logic [1:0]           lsu_op_size_i,
  input  logic                 lsu_unsigned_i,
  input  logic [AddrWidth-1:0] lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_busy_o,
  output logic [DataWidth-1:0] lsu_rdata_o,
  output logic                 lsu_misaligned_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [DataWidth-1:0] data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   mis_q, mis_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [1:0]             off_q, off_d;

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      2'b10:   return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] store_lanes(input logic [1:0] size,
                                                       input logic [DataWidth-1:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [DataWidth-1:0] load_extend(input logic [1:0] size,
                                                       input logic uns,
                                                       input logic [1:0] off,
                                                       input logic [DataWidth-1:0] rdata);
    logic [DataWidth-1:0] lane;
    logic signed [7:0]    lane_b;
    logic signed [15:0]   lane_h;
    lane   = rdata >> {off, 3'b000};
    lane_b = lane[7:0];
    lane_h = lane[15:0];
    case (size)
      2'b00:   return uns ? {{(DataWidth-8){1'b0}}, lane[7:0]} : DataWidth'(lane_b);
      2'b01:   return uns ? {{(DataWidth-16){1'b0}}, lane[15:0]} : DataWidth'(lane_h);
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (lsu_en_i) begin
          if (is_legal(lsu_op_size_i, lsu_addr_i[1:0])) begin
            size_d  = lsu_op_size_i;
            uns_d   = lsu_unsigned_i;
            off_d   = lsu_addr_i[1:0];
            addr_d  = {lsu_addr_i[AddrWidth-1:2], 2'b00};
            we_d    = lsu_op_i;
            be_d    = byte_en(lsu_op_size_i, lsu_addr_i[1:0]);
            wdata_d = store_lanes(lsu_op_size_i, lsu_wdata_i);
            mis_d   = 1'b0;
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            mis_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Load data is registered on the rvalid edge so it is ready when busy falls.
        if (data_rvalid_i) begin
          state_d = IDLE;
          if (!we_q) begin
            rdata_d = load_extend(size_q, uns_q, off_q, data_rdata_i);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
    end
  end

  assign lsu_busy_o       = busy_q;
  assign lsu_rdata_o      = rdata_q;
  assign lsu_misaligned_o = mis_q;
  assign data_req_o       = req_q;
  assign data_addr_o      = addr_q;
  assign data_we_o        = we_q;
  assign data_be_o        = be_q;
  assign data_wdata_o     = wdata_q;

endmodule

// File: tb/tb_beta_exe_lsu.sv
// Scoreboard bench for beta_exe_lsu: randomized operations against a byte-level
// reference model, with a bus responder that stalls grant/rvalid by random amounts.
module tb_beta_exe_lsu;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          len;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        op;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] rdata;
  logic        mis;
  logic        req;
  logic        gnt;
  logic [31:0] baddr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] bwdata;
  logic        rvalid;
  logic [31:0] brdata;

  int          vectors = 0;
  int          miscompares = 0;
  bus_t        exp_bus[$];
  done_t       exp_done[$];
  logic [31:0] model_rdata = 32'h0;
  int          gd = 0;
  int          rd = 0;
  logic [31:0] cur_rdata = 32'h0;

  always #5 clk = ~clk;

  beta_exe_lsu #(.DataWidth(32), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_en_i(en), .lsu_op_i(op), .lsu_op_size_i(size), .lsu_unsigned_i(uns),
    .lsu_addr_i(addr), .lsu_wdata_i(wdata),
    .lsu_busy_o(busy), .lsu_rdata_o(rdata), .lsu_misaligned_o(mis),
    .data_req_o(req), .data_gnt_i(gnt), .data_addr_o(baddr), .data_we_o(we),
    .data_be_o(be), .data_wdata_o(bwdata), .data_rvalid_i(rvalid), .data_rdata_i(brdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_legal(input logic [1:0] s, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    if (s == 2'd0) return 1'b1;
    if (s == 2'd1) return (o % 2) == 0;
    if (s == 2'd2) return o == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
    int o;
    o = int'(a[1:0]);
    if (s == 2'd0) return 4'(1 << o);
    if (s == 2'd1) return (o == 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] w);
    if (s == 2'd0) return 32'(w[7:0]) * 32'h01010101;
    if (s == 2'd1) return 32'(w[15:0]) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] s, input logic u,
                                         input logic [31:0] a, input logic [31:0] r);
    logic [7:0] bt[4];
    int o;
    o = int'(a[1:0]);
    for (int k = 0; k < 4; k++) bt[k] = r[8*k +: 8];
    if (s == 2'd0) begin
      if (!u && bt[o][7]) return {24'hFFFFFF, bt[o]};
      return {24'h0, bt[o]};
    end
    if (s == 2'd1) begin
      if (!u && bt[o+1][7]) return {16'hFFFF, bt[o+1], bt[o]};
      return {16'h0, bt[o+1], bt[o]};
    end
    return r;
  endfunction

  // Issue one operation at a negedge with the DUT idle; returns at the negedge busy is low.
  task automatic issue(input logic o, input logic [1:0] s, input logic u, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] r, input int g, input int d);
    bus_t  bx;
    done_t dx;
    int    t;
    gd = g; rd = d; cur_rdata = r;
    op = o; size = s; uns = u; addr = a; wdata = w; en = 1'b1;
    if (m_legal(s, a)) begin
      bx.addr = {a[31:2], 2'b00};
      bx.be = m_be(s, a);
      bx.we = o;
      bx.wdata = m_wdata(s, w);
      exp_bus.push_back(bx);
      if (!o) model_rdata = m_load(s, u, a, r);
      dx.rdata = model_rdata; dx.mis = 1'b0; dx.len = g + d + 2;
    end else begin
      dx.rdata = model_rdata; dx.mis = 1'b1; dx.len = 1;
    end
    exp_done.push_back(dx);
    @(negedge clk);
    t = 0;
    while (busy && t < 200) begin
      en = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      wdata = $urandom;
      @(negedge clk);
      t++;
    end
    en = 1'b0;
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still %0d after %0d cycles", busy, t);
    end
  endtask

  // Bus responder: grant after gd request cycles, rvalid after rd wait cycles, noise elsewhere.
  initial begin
    int  cnt;
    int  wcnt;
    bit  wait_phase;
    cnt = 0; wcnt = 0; wait_phase = 0;
    gnt = 1'b0; rvalid = 1'b0; brdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wait_phase = 0; cnt = 0; gnt = 1'b0; rvalid = 1'b0;
      end else if (wait_phase) begin
        gnt = 1'($urandom_range(0, 1));
        rvalid = (wcnt == rd);
        brdata = rvalid ? cur_rdata : $urandom;
        if (rvalid) wait_phase = 0;
        wcnt++;
      end else if (req) begin
        gnt = (cnt == gd);
        rvalid = 1'($urandom_range(0, 1));
        brdata = $urandom;
        cnt++;
        if (gnt) begin
          wait_phase = 1;
          wcnt = 0;
        end
      end else begin
        cnt = 0;
        gnt = 1'($urandom_range(0, 1));
        rvalid = 1'($urandom_range(0, 1));
        brdata = $urandom;
      end
    end
  end

  // Monitor: bus request fields on every request cycle, results when busy falls.
  initial begin
    bus_t  cur;
    done_t dx;
    bit    prev_req;
    bit    prev_busy;
    int    blen;
    prev_req = 0; prev_busy = 0; blen = 0;
    cur.addr = 32'h0; cur.be = 4'h0; cur.we = 1'b0; cur.wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0; prev_busy = 0; blen = 0;
      end else begin
        if (req) begin
          if (!prev_req) begin
            if (exp_bus.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_req: addr %h with no request expected", baddr);
            end else begin
              cur = exp_bus.pop_front();
            end
          end
          chk("bus_addr", baddr, cur.addr);
          chk("bus_be", {28'h0, be}, {28'h0, cur.be});
          chk("bus_we", {31'h0, we}, {31'h0, cur.we});
          chk("bus_wdata", bwdata, cur.wdata);
        end
        if (busy) blen++;
        if (prev_busy && !busy) begin
          if (exp_done.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: busy fell with no operation expected");
          end else begin
            dx = exp_done.pop_front();
            chk("lsu_rdata", rdata, dx.rdata);
            chk("lsu_misaligned", {31'h0, mis}, {31'h0, dx.mis});
            chk("busy_len", 32'(blen), 32'(dx.len));
          end
          blen = 0;
        end
        prev_req = req;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus_t bx;
    rst = 1'b1; en = 1'b0; op = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_req", {31'h0, req}, 32'h0);
    chk("reset_be", {28'h0, be}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mis", {31'h0, mis}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h5555AAAA, 32'hDEADBEEF, 0, 0);
    chk("word_load", rdata, 32'hDEADBEEF);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 0);
    chk("byte_signed", rdata, 32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 1, 0);
    chk("byte_unsigned", rdata, 32'h00000080);
    issue(1'b1, 2'd1, 1'b0, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1);
    chk("half_store_keeps_rdata", rdata, 32'h00000080);
    issue(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 3, 2);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h11111111, 0, 0);
    chk("misaligned_word", {31'h0, mis}, 32'h1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h22222222, 0, 0);
    chk("reserved_size", {31'h0, mis}, 32'h1);
    issue(1'b0, 2'd1, 1'b1, 32'h002, 32'h0, 32'h8765F321, 0, 0);
    chk("legal_clears_mis", {31'h0, mis}, 32'h0);
    chk("half_unsigned", rdata, 32'h00008765);

    for (int i = 0; i < 200; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting for rvalid, with a stray enable pulse while busy.
    gd = 0; rd = 50; cur_rdata = 32'h13579BDF;
    op = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h400; en = 1'b1;
    bx.addr = 32'h400; bx.be = 4'hF; bx.we = 1'b0; bx.wdata = wdata;
    exp_bus.push_back(bx);
    @(negedge clk);
    en = 1'b0;
    t = 0;
    while (!(busy && !req) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wait", {30'h0, busy, req}, 32'h2);
    op = 1'b1; size = 2'd2; addr = 32'h500; wdata = 32'hA5A5A5A5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_req", {31'h0, req}, 32'h0);
    chk("rst_mid_we", {31'h0, we}, 32'h0);
    chk("rst_mid_be", {28'h0, be}, 32'h0);
    chk("rst_mid_addr", baddr, 32'h0);
    chk("rst_mid_wdata", bwdata, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_mis", {31'h0, mis}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", {30'h0, busy, req}, 32'h0);
    end
    chk("queues_drained", 32'(exp_bus.size() + exp_done.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
